alu_pipe_ctl: RTL and testbench

- Parametrised, sequential successor to the team's fixed 16-bit, 2-bit-op combinational ALU.
- Keeps the original four ops (ADD/SUB/AND/NOTB) and adds an iterative shift-add multiply.
- Adds registered result and status flags (Z, N, V) and valid/ready handshakes on input and output.
- Sits between register-file read and writeback in the datapath; the controller FSM stalls on the handshakes.

---
 rtl/alu_pipe_ctl.sv | 181 ++++++++++++++++++
 tb/tb_alu_pipe_ctl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_ctl.sv
// alu_pipe_ctl: sequential ALU with valid/ready handshakes on both sides.
// Single-cycle ops (ADD, SUB, AND, NOTB, reserved) finish one cycle after
// acceptance. MUL runs an iterative shift-add for WIDTH cycles in BUSY.
// The result and {V,N,Z} flags are registered and held in DONE until the
// consumer takes them.
module alu_pipe_ctl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [2:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       status,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOTB = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t state;
  state_t state_next;

  logic accept;
  logic take;

  // Multiply datapath: running sum, shifted-left multiplicand, shifted-right multiplier.
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_step;
  logic             last_iter;

  // Single-cycle result and its overflow flag, computed from the live inputs.
  logic [WIDTH-1:0] alu_res;
  logic             alu_v;

  assign accept    = in_valid & in_ready;
  assign take      = out_valid & out_ready;
  assign last_iter = (count == '0);

  // Combinational result for the ops that finish in the acceptance cycle.
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (ALUop)
      OP_ADD: begin
        alu_res = Ain + Bin;
        alu_v   = (Ain[WIDTH-1] == Bin[WIDTH-1]) && (alu_res[WIDTH-1] != Ain[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = Ain - Bin;
        alu_v   = (Ain[WIDTH-1] != Bin[WIDTH-1]) && (alu_res[WIDTH-1] != Ain[WIDTH-1]);
      end
      OP_AND: begin
        alu_res = Ain & Bin;
      end
      OP_NOTB: begin
        alu_res = ~Bin;
      end
      default: begin
        alu_res = '0;
        alu_v   = 1'b0;
      end
    endcase
  end

  // One shift-add step: add the multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_step = acc;
    if (mplier[0]) begin
      acc_step = acc + mcand;
    end
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: MUL detours through BUSY, everything else goes straight to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (ALUop == OP_MUL) begin
            state_next = BUSY;
          end else begin
            state_next = DONE;
          end
        end
      end
      BUSY: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (take) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    in_ready  = (state == IDLE) && !reset;
    out_valid = (state == DONE);
    busy      = (state == BUSY);
  end

  // Datapath registers: latch operands on accept, iterate in BUSY, hold in DONE/IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      out    <= '0;
      status <= '0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (ALUop == OP_MUL) begin
              count  <= CNT_LOAD;
              acc    <= '0;
              mcand  <= Ain;
              mplier <= Bin;
            end else begin
              out    <= alu_res;
              status <= {alu_v, alu_res[WIDTH-1], (alu_res == '0)};
            end
          end
        end
        BUSY: begin
          acc    <= acc_step;
          mcand  <= {mcand[WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          if (last_iter) begin
            out    <= acc_step;
            status <= {1'b0, acc_step[WIDTH-1], (acc_step == '0)};
          end else begin
            count <= count - CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe_ctl.sv
// tb_alu_pipe_ctl: self-checking bench for alu_pipe_ctl at WIDTH=16.
// Expected results come from an arithmetic reference model of the ALU ops.
module tb_alu_pipe_ctl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Ain;
  logic [15:0] Bin;
  logic [2:0]  ALUop;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic [2:0]  status;
  logic        busy;

  int total;
  int bad;

  alu_pipe_ctl #(.WIDTH(16), .CNT_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Ain       (Ain),
    .Bin       (Bin),
    .ALUop     (ALUop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .status    (status),
    .busy      (busy)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: returns {result, V, N, Z} from plain integer arithmetic.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] op);
    int          sa;
    int          sb;
    int          sr;
    longint      p;
    logic [15:0] r;
    logic        v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    v  = 1'b0;
    r  = 16'h0000;
    case (op)
      3'd0: begin
        r  = 16'((int'(a) + int'(b)) % 65536);
        sr = sa + sb;
        v  = (sr > 32767) || (sr < -32768);
      end
      3'd1: begin
        r  = 16'((int'(a) - int'(b) + 65536) % 65536);
        sr = sa - sb;
        v  = (sr > 32767) || (sr < -32768);
      end
      3'd2: r = a & b;
      3'd3: r = 16'(65535 - int'(b));
      3'd4: begin
        p = (longint'(a) * longint'(b)) % 65536;
        r = 16'(p);
      end
      default: r = 16'h0000;
    endcase
    return {r, v, (r >= 16'h8000), (r == 16'h0000)};
  endfunction

  // Issue one op with out_ready=1 and collect result, latency and BUSY observations.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                        output logic [15:0] o, output logic [2:0] st, output int lat,
                        output int busy_cyc, output int rdy_busy, output bit to);
    int w;
    to       = 1'b0;
    lat      = 0;
    busy_cyc = 0;
    rdy_busy = 0;
    w        = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) to = 1'b1;
    Ain       = a;
    Bin       = b;
    ALUop     = op;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    Ain      = 16'($urandom);
    Bin      = 16'($urandom);
    lat      = 1;
    while (!out_valid && lat < 100) begin
      if (busy) busy_cyc++;
      if (in_ready) rdy_busy++;
      @(negedge clk);
      lat++;
    end
    if (!out_valid) to = 1'b1;
    o  = out;
    st = status;
  endtask

  // Reset values, including in_ready forced low while reset is asserted.
  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Ain       = '0;
    Bin       = '0;
    ALUop     = '0;
    repeat (2) @(negedge clk);
    total++;
    if (out !== 16'h0000 || status !== 3'b000 || out_valid !== 1'b0 || busy !== 1'b0
        || in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_state: out=%h status=%b out_valid=%b busy=%b in_ready=%b, required 0000/000/0/0/0",
               out, status, out_valid, busy, in_ready);
    end
    reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_release_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  // Directed single-cycle ops: overflow, zero, borrow overflow, reserved op.
  task automatic test_single_cycle();
    logic [15:0] o;
    logic [2:0]  st;
    int          lat, bc, rb;
    bit          to;
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [2:0]  vo [4];
    logic [15:0] eo [4];
    logic [2:0]  es [4];
    va[0] = 16'h7FFF; vb[0] = 16'h0001; vo[0] = 3'b000; eo[0] = 16'h8000; es[0] = 3'b110;
    va[1] = 16'h0005; vb[1] = 16'h0005; vo[1] = 3'b001; eo[1] = 16'h0000; es[1] = 3'b001;
    va[2] = 16'h8000; vb[2] = 16'h0001; vo[2] = 3'b001; eo[2] = 16'h7FFF; es[2] = 3'b100;
    va[3] = 16'h1234; vb[3] = 16'h5678; vo[3] = 3'b110; eo[3] = 16'h0000; es[3] = 3'b001;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vo[i], o, st, lat, bc, rb, to);
      total++;
      if (to || o !== eo[i] || st !== es[i] || lat != 1) begin
        bad++;
        $display("[TB] FAIL single_cycle_%0d: out=%h status=%b lat=%0d to=%0d, required %h/%b/1",
                 i, o, st, lat, to, eo[i], es[i]);
      end
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL after_handoff_%0d: in_ready=%b out_valid=%b, required 1/0",
                 i, in_ready, out_valid);
      end
    end
  endtask

  // Directed multiplies: busy duration, in_ready low, latency WIDTH+1.
  task automatic test_mul();
    logic [15:0] o;
    logic [2:0]  st;
    int          lat, bc, rb;
    bit          to;
    run_op(16'h0123, 16'h0010, 3'b100, o, st, lat, bc, rb, to);
    total++;
    if (to || o !== 16'h1230 || st !== 3'b000 || lat != 17 || bc != 16 || rb != 0) begin
      bad++;
      $display("[TB] FAIL mul_basic: out=%h status=%b lat=%0d busy=%0d ready_in_busy=%0d, required 1230/000/17/16/0",
               o, st, lat, bc, rb);
    end
    run_op(16'h8000, 16'h0002, 3'b100, o, st, lat, bc, rb, to);
    total++;
    if (to || o !== 16'h0000 || st !== 3'b001 || lat != 17) begin
      bad++;
      $display("[TB] FAIL mul_wrap: out=%h status=%b lat=%0d, required 0000/001/17", o, st, lat);
    end
  endtask

  // Backpressure: result held in DONE, new operands wait until after the hand-off.
  task automatic test_backpressure();
    logic [15:0] na, nb;
    logic [18:0] exp;
    @(negedge clk);
    Ain       = 16'hF0F0;
    Bin       = 16'h3C3C;
    ALUop     = 3'b010;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      Ain   = 16'($urandom);
      Bin   = 16'($urandom);
      ALUop = 3'b000;
      total++;
      if (out !== 16'h3030 || status !== 3'b000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL hold_%0d: out=%h status=%b out_valid=%b in_ready=%b, required 3030/000/1/0",
                 i, out, status, out_valid, in_ready);
      end
    end
    na = Ain;
    nb = Bin;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL after_take: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    exp = model(na, nb, 3'b000);
    total++;
    if (out_valid !== 1'b1 || out !== exp[18:3] || status !== exp[2:0]) begin
      bad++;
      $display("[TB] FAIL late_accept: out_valid=%b out=%h status=%b, required 1/%h/%b",
               out_valid, out, status, exp[18:3], exp[2:0]);
    end
  endtask

  // Reset in the 8th BUSY cycle discards the multiply; a NOTB follows cleanly.
  task automatic test_reset_mid_mul();
    logic [15:0] o;
    logic [2:0]  st;
    int          lat, bc, rb;
    bit          to;
    @(negedge clk);
    Ain       = 16'($urandom) | 16'h0001;
    Bin       = 16'($urandom) | 16'h0001;
    ALUop     = 3'b100;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL busy_8th: busy=%b required 1", busy);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (out !== 16'h0000 || status !== 3'b000 || out_valid !== 1'b0 || busy !== 1'b0
        || in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL abort_mul: out=%h status=%b out_valid=%b busy=%b in_ready=%b, required 0000/000/0/0/1",
               out, status, out_valid, busy, in_ready);
    end
    run_op(16'h1234, 16'h00FF, 3'b011, o, st, lat, bc, rb, to);
    total++;
    if (to || o !== 16'hFF00 || st !== 3'b010 || lat != 1) begin
      bad++;
      $display("[TB] FAIL notb_after_abort: out=%h status=%b lat=%0d, required ff00/010/1", o, st, lat);
    end
  endtask

  // Random ops of every opcode against the reference model.
  task automatic test_random();
    logic [15:0] a, b, o;
    logic [2:0]  op, st;
    logic [18:0] exp;
    int          lat, bc, rb, elat;
    bit          to;
    for (int i = 0; i < 40; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      op = 3'($urandom_range(0, 7));
      if (i % 8 == 0) a = 16'h8000;
      if (i % 8 == 1) b = 16'hFFFF;
      exp  = model(a, b, op);
      elat = (op == 3'b100) ? 17 : 1;
      run_op(a, b, op, o, st, lat, bc, rb, to);
      total++;
      if (to || o !== exp[18:3] || st !== exp[2:0] || lat != elat || rb != 0) begin
        bad++;
        $display("[TB] FAIL random_%0d op=%b a=%h b=%h: out=%h status=%b lat=%0d, required %h/%b/%0d",
                 i, op, a, b, o, st, lat, exp[18:3], exp[2:0], elat);
      end
    end
  endtask

  // Test sequence and summary.
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_cycle();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_random();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
